// File: rtl/i2c_lcd_ctrl.sv
// HD44780 4-bit command sequencer driving a PCF8574 expander via simple_i2c.
// Optional: define I2C_LCD_BACKLIGHT_EN to take the BL bit from bl_on.
module i2c_lcd_ctrl #(
   parameter int unsigned PWRUP_DLY = 2_000_000,
   parameter int unsigned CMD_DLY   = 2_500,
   parameter int unsigned LONG_DLY  = 100_000,
   parameter int unsigned BUSY_TO   = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rs,
   input  logic [7:0] cmd_data,
   input  logic       bl_on,
   output logic [7:0] i2c_data,
   output logic       i2c_we,
   input  logic       i2c_busy,
   input  logic       i2c_error,
   output logic       init_done,
   output logic       error
);

   typedef enum logic [2:0] {
      S_PWRUP, S_FETCH, S_ISSUE, S_ACKW,
      S_DONEW, S_DELAY, S_IDLE, S_ERROR
   } state_e;

   state_e      state_q;
   logic [31:0] cnt_q;
   logic [2:0]  item_q;
   logic [1:0]  wr_q;
   logic [7:0]  byte_q;
   logic        rs_q;
   logic        nib_q;
   logic        long_q;
   logic        hrs_q;
   logic [7:0]  hdata_q;
   logic        ready_q;
   logic        we_q;
   logic [7:0]  data_q;
   logic        done_q;
   logic        err_q;

   logic        bl_d;
   logic [3:0]  nib_d;
   logic [7:0]  exp_d;
   logic        last_d;
   logic [31:0] dly_d;
   logic        f_nib_d;
   logic [7:0]  f_byte_d;
   logic        f_rs_d;
   logic        f_long_d;

   // {nibble_only, byte}; nibble-only items carry their nibble in [7:4]
   function automatic logic [8:0] init_item(input logic [2:0] i);
      case (i)
         3'd0, 3'd1, 3'd2: return {1'b1, 8'h30};
         3'd3:             return {1'b1, 8'h20};
         3'd4:             return {1'b0, 8'h28};
         3'd5:             return {1'b0, 8'h0C};
         3'd6:             return {1'b0, 8'h01};
         default:          return {1'b0, 8'h06};
      endcase
   endfunction

   always_comb begin
`ifdef I2C_LCD_BACKLIGHT_EN
      bl_d = done_q ? bl_on : 1'b1;
`else
      // bl_on has no effect here; the OR only keeps the port referenced
      bl_d = bl_on | 1'b1;
`endif
      nib_d  = wr_q[1] ? byte_q[3:0] : byte_q[7:4];
      exp_d  = {nib_d, bl_d, ~wr_q[0], 1'b0, rs_q};
      last_d = nib_q ? (wr_q == 2'd1) : (wr_q == 2'd3);
      dly_d  = long_q ? LONG_DLY - 1 : CMD_DLY - 1;

      f_nib_d  = 1'b0;
      f_byte_d = hdata_q;
      f_rs_d   = hrs_q;
      if (!done_q) begin
         {f_nib_d, f_byte_d} = init_item(item_q);
         f_rs_d = 1'b0;
      end
      f_long_d = f_nib_d |
         (!f_rs_d && (f_byte_d inside {8'h01, 8'h02, 8'h03}));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_PWRUP;
         cnt_q   <= PWRUP_DLY - 1;
         item_q  <= '0;
         wr_q    <= '0;
         byte_q  <= '0;
         rs_q    <= 1'b0;
         nib_q   <= 1'b0;
         long_q  <= 1'b0;
         hrs_q   <= 1'b0;
         hdata_q <= '0;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         data_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         we_q <= 1'b0;
         if (i2c_error &&
             !(state_q inside {S_PWRUP, S_IDLE, S_ERROR})) begin
            state_q <= S_ERROR;
            err_q   <= 1'b1;
            ready_q <= 1'b0;
         end else begin
            unique case (state_q)
               S_PWRUP: begin
                  if (cnt_q == 0) state_q <= S_FETCH;
                  else            cnt_q   <= cnt_q - 32'd1;
               end
               S_FETCH: begin
                  wr_q    <= '0;
                  nib_q   <= f_nib_d;
                  byte_q  <= f_byte_d;
                  rs_q    <= f_rs_d;
                  long_q  <= f_long_d;
                  state_q <= S_ISSUE;
               end
               S_ISSUE: begin
                  if (!i2c_busy) begin
                     data_q  <= exp_d;
                     we_q    <= 1'b1;
                     cnt_q   <= BUSY_TO;
                     state_q <= S_ACKW;
                  end
               end
               S_ACKW: begin
                  if (i2c_busy) begin
                     state_q <= S_DONEW;
                  end else if (cnt_q == 0) begin
                     state_q <= S_ERROR;
                     err_q   <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q - 32'd1;
                  end
               end
               S_DONEW: begin
                  if (!i2c_busy) begin
                     if (last_d) begin
                        cnt_q   <= dly_d;
                        state_q <= S_DELAY;
                     end else begin
                        wr_q    <= wr_q + 2'd1;
                        state_q <= S_ISSUE;
                     end
                  end
               end
               S_DELAY: begin
                  if (cnt_q != 0) begin
                     cnt_q <= cnt_q - 32'd1;
                  end else if (done_q || item_q == 3'd7) begin
                     done_q  <= 1'b1;
                     ready_q <= 1'b1;
                     state_q <= S_IDLE;
                  end else begin
                     item_q  <= item_q + 3'd1;
                     state_q <= S_FETCH;
                  end
               end
               S_IDLE: begin
                  if (cmd_valid) begin
                     hrs_q   <= cmd_rs;
                     hdata_q <= cmd_data;
                     ready_q <= 1'b0;
                     state_q <= S_FETCH;
                  end
               end
               S_ERROR: begin
                  err_q   <= 1'b1;
                  ready_q <= 1'b0;
               end
               default: state_q <= S_ERROR;
            endcase
         end
      end
   end

   assign cmd_ready = ready_q;
   assign i2c_we    = we_q;
   assign i2c_data  = data_q;
   assign init_done = done_q;
   assign error     = err_q;

endmodule
